// File: rtl/ov7670_gen_pkg.sv
// Shared types and constants for the OV7670 stream generator.
package ov7670_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t VSYNC  = 3'd1;
  localparam state_t VBACK  = 3'd2;
  localparam state_t ACTIVE = 3'd3;
  localparam state_t HBLANK = 3'd4;
  localparam state_t VFRONT = 3'd5;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_t;

  localparam logic [11:0] BAR_RGB [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  localparam logic [11:0] LFSR_SEED = 12'hACE;

  // Fibonacci LFSR, polynomial x^12 + x^6 + x^4 + x + 1
  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

endpackage

// File: rtl/ov7670_pattern_src.sv
// Registered RGB444 test-pattern pixel source; loads one pixel per fetch strobe.
// OV7670_GEN_LFSR_EN: pattern 3 becomes LFSR noise instead of solid_rgb.
module ov7670_pattern_src
  import ov7670_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        fetch,
  input  logic [11:0] x,
  input  logic [4:0]  y,
  input  logic [3:0]  frame,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
  output logic [11:0] rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BW-1:0] bar_px_q, cur_px;
  logic [2:0]    bar_idx_q, cur_idx;
  logic [11:0]   pix;

`ifdef OV7670_GEN_LFSR_EN
  logic [11:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (frame_start) begin
      lfsr_q <= LFSR_SEED;
    end else if (fetch) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`endif

  // Bar position tracks the next pixel; x == 0 restarts it at each line.
  always_comb begin
    cur_idx = (x == '0) ? 3'd0 : bar_idx_q;
    cur_px  = (x == '0) ? '0 : bar_px_q;
    pix     = 12'h000;
    case (pattern_t'(pattern))
      PAT_BARS:    pix = BAR_RGB[cur_idx];
      PAT_RAMP:    pix = {x[3:0], y[3:0], frame};
      PAT_CHECKER: pix = (x[4] ^ y[4]) ? 12'hFFF : 12'h000;
      default: begin
`ifdef OV7670_GEN_LFSR_EN
        pix = lfsr_q;
`else
        pix = solid_rgb;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= 12'h000;
      bar_px_q  <= '0;
      bar_idx_q <= 3'd0;
    end else if (fetch) begin
      rgb <= pix;
      if (cur_px == BW'(BAR_W - 1)) begin
        bar_px_q  <= '0;
        bar_idx_q <= cur_idx + 3'd1;
      end else begin
        bar_px_q  <= cur_px + 1'b1;
        bar_idx_q <= cur_idx;
      end
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: VSYNC/HREF/byte frames of RGB444 test patterns, one byte per clk.
// OV7670_GEN_LFSR_EN selects LFSR noise for pattern 3. All timing parameters must be >= 1.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned L  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW = $clog2(L);
  localparam int unsigned LW = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(2 * H_ACTIVE - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]    pat_q;
  logic [11:0]   solid_q;
  logic          line_end, frame_start_d, frame_done;
  logic          fetch;
  logic [11:0]   fetch_x;
  logic [4:0]    fetch_y;
  logic [11:0]   rgb;
  logic [7:0]    d_d;

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    frame_start_d = 1'b0;
    frame_done    = 1'b0;
    line_end      = (hcnt_q == H_LAST);
    if (state_q == IDLE) begin
      hcnt_d = '0;
      lcnt_d = '0;
      if (enable) begin
        state_d       = VSYNC;
        frame_start_d = 1'b1;
      end
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      case (state_q)
        VSYNC: begin
          if (line_end) begin
            if (lcnt_q == LW'(VSYNC_LINES - 1)) begin
              state_d = VBACK;
              lcnt_d  = '0;
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end
        end
        VBACK: begin
          if (line_end) begin
            if (lcnt_q == LW'(V_BACK - 1)) begin
              state_d = ACTIVE;
              lcnt_d  = '0;
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (hcnt_q == H_ACT_LAST) state_d = HBLANK;
        end
        HBLANK: begin
          if (line_end) begin
            if (lcnt_q == LW'(V_ACTIVE - 1)) begin
              state_d = VFRONT;
              lcnt_d  = '0;
            end else begin
              state_d = ACTIVE;
              lcnt_d  = lcnt_q + 1'b1;
            end
          end
        end
        VFRONT: begin
          if (line_end) begin
            if (lcnt_q == LW'(V_FRONT - 1)) begin
              frame_done = 1'b1;
              lcnt_d     = '0;
              // enable is only honoured here, so frames are never truncated
              if (enable) begin
                state_d       = VSYNC;
                frame_start_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prefetch: the pixel source loads pixel x on the cycle before its byte0 is emitted.
  always_comb begin
    fetch   = 1'b0;
    fetch_x = 12'h000;
    fetch_y = 5'd0;
    if (hcnt_d == H_LAST) begin
      if (state_d == VBACK && lcnt_d == LW'(V_BACK - 1)) begin
        fetch = 1'b1;
      end else if (state_d == HBLANK && lcnt_d != LW'(V_ACTIVE - 1)) begin
        fetch   = 1'b1;
        fetch_y = 5'(32'(lcnt_d) + 1);
      end
    end else if (state_d == ACTIVE && hcnt_d[0] && hcnt_d != H_ACT_LAST) begin
      fetch   = 1'b1;
      fetch_x = 12'((32'(hcnt_d) + 1) >> 1);
      fetch_y = 5'(lcnt_d);
    end
  end

  always_comb begin
    d_d = 8'h00;
    if (state_d == ACTIVE) d_d = hcnt_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  ov7670_pattern_src #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_src (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start_d),
    .fetch       (fetch),
    .x           (fetch_x),
    .y           (fetch_y),
    .frame       (frame_count[3:0]),
    .pattern     (pat_q),
    .solid_rgb   (solid_q),
    .rgb         (rgb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      pat_q       <= 2'd0;
      solid_q     <= 12'h000;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_start <= 1'b0;
      frame_count <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      vsync       <= (state_d == VSYNC);
      href        <= (state_d == ACTIVE);
      d           <= d_d;
      frame_start <= frame_start_d;
      busy        <= (state_d != IDLE);
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (frame_start_d) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a tiny frame geometry (L=36, 252 cycles/frame).
module tb_ov7670_stream_gen;

  localparam int HA    = 16;
  localparam int VA    = 4;
  localparam int L     = 36;
  localparam int FRAME = 252;

  localparam logic [11:0] BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        vsync, href, frame_start, busy;
  logic [7:0]  d;
  logic [15:0] frame_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [11:0] cap_px [64];
  int          cap_n;

  ov7670_stream_gen #(
    .H_ACTIVE    (16),
    .V_ACTIVE    (4),
    .H_BLANK     (4),
    .VSYNC_LINES (1),
    .V_BACK      (1),
    .V_FRONT     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int pat, input int x, input int y, input int f,
                                          input logic [11:0] solid);
    case (pat)
      0:       return BARS[x / (HA / 8)];
      1:       return {4'(x), 4'(y), 4'(f)};
      2:       return (((x ^ y) & 16) != 0) ? 12'hFFF : 12'h000;
      default: return solid;
    endcase
  endfunction

  // Steps n_cyc cycles from the first VSYNC cycle, checking every output against the frame
  // timing, and captures pixels the way a downstream byte-pair receiver would.
  task automatic run_frame(input int pat, input logic [11:0] solid, input int f, input int n_cyc,
                           input int chg_at, input logic [1:0] new_pat,
                           input logic [11:0] new_solid, input int drop_at);
    int          line, h;
    logic        exp_href, ph;
    logic [11:0] px;
    logic [7:0]  exp_d;
    logic [3:0]  r;
    cap_n = 0;
    ph    = 1'b0;
    r     = 4'h0;
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      line     = c / L;
      h        = c % L;
      exp_href = (line >= 2) && (line < 2 + VA) && (h < 2 * HA);
      exp_d    = 8'h00;
      if (exp_href) begin
        px    = exp_rgb(pat, h / 2, line - 2, f, solid);
        exp_d = (h % 2 == 0) ? {4'h0, px[11:8]} : px[7:0];
      end
      check("vsync", 32'(vsync), 32'(line == 0));
      check("href", 32'(href), 32'(exp_href));
      check("d", 32'(d), 32'(exp_d));
      check("frame_start", 32'(frame_start), 32'(c == 0));
      check("busy", 32'(busy), 32'd1);
      check("frame_count", 32'(frame_count), 32'(f));
      if (href) begin
        if (!ph) begin
          r = d[3:0];
        end else begin
          if (cap_n < 64) cap_px[cap_n] = {r, d};
          cap_n++;
        end
        ph = ~ph;
      end else begin
        ph = 1'b0;
      end
      if (c == chg_at) begin
        pattern_sel = new_pat;
        solid_rgb   = new_solid;
      end
      if (c == drop_at) enable = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;

    // Bars; switch to ramp mid-frame, which must only take effect next frame.
    run_frame(0, 12'h000, 0, FRAME, 100, 2'd1, 12'h000, -1);
    // Ramp, f=1; switch to solid 5A3 during an active line.
    run_frame(1, 12'h000, 1, FRAME, 150, 2'd3, 12'h5A3, -1);
    check("cap_count_f1", 32'(cap_n), 32'd64);
    check("cap_x5_y2_f1", 32'(cap_px[37]), 32'h521);
    // Solid 05,A3; solid_rgb changed during VBACK must not leak in.
    run_frame(3, 12'h5A3, 2, FRAME, 60, 2'd2, 12'h000, -1);
    check("cap_solid", 32'(cap_px[20]), 32'h5A3);
    // Checker; drop enable mid active line, frame must still complete.
    run_frame(2, 12'h000, 3, FRAME, -1, 2'd0, 12'h000, 90);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_vsync", 32'(vsync), 32'd0);
      check("idle_href", 32'(href), 32'd0);
      check("idle_frame_count", 32'(frame_count), 32'd4);
    end

    // Restart, then reset asynchronously during an href cycle.
    pattern_sel = 2'd0;
    enable      = 1'b1;
    run_frame(0, 12'h000, 4, 81, -1, 2'd0, 12'h000, -1);
    rst = 1'b1;
    #1;
    check("async_href", 32'(href), 32'd0);
    check("async_vsync", 32'(vsync), 32'd0);
    check("async_d", 32'(d), 32'd0);
    check("async_frame_count", 32'(frame_count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 12'h000, 0, FRAME, -1, 2'd0, 12'h000, -1);

    // Ramp in frame 0 after a fresh reset: captured stream layout.
    rst         = 1'b1;
    pattern_sel = 2'd1;
    @(negedge clk);
    rst = 1'b0;
    run_frame(1, 12'h000, 0, FRAME, -1, 2'd0, 12'h000, -1);
    check("cap_count_f0", 32'(cap_n), 32'd64);
    check("cap_x5_y2_f0", 32'(cap_px[37]), 32'h520);
    check("cap_first", 32'(cap_px[0]), 32'h000);
    check("cap_last", 32'(cap_px[63]), 32'hF30);
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
